// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative cache controller: tag/valid/dirty/LRU state, next-level messages, saturating stats.
// Optional build macro WRITE_THROUGH_EN selects write-through / no-write-allocate behaviour.
module assoc_cache_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned SETS       = 256,
  parameter int unsigned WAYS       = 4,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd,
  input  logic [ADDR_W-1:0] addr,
  output logic              l2_valid,
  output logic [1:0]        l2_op,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [CNT_W-1:0]  reads_cnt,
  output logic [CNT_W-1:0]  writes_cnt,
  output logic [CNT_W-1:0]  hits_cnt,
  output logic [CNT_W-1:0]  misses_cnt
);

  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned LINE_W = ADDR_W - OFF_W;
  localparam int unsigned TAG_W  = LINE_W - IDX_W;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned AGE_W  = WAY_W;

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WB    = 2'd2;
  localparam logic [1:0] OP_WRITE = 2'd3;

`ifdef WRITE_THROUGH_EN
  localparam bit WRITE_THROUGH = 1'b1;
`else
  localparam bit WRITE_THROUGH = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_WB} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_cmd_ready;
  logic [3:0]          r_cmd;
  logic [LINE_W-1:0]   r_line;
  logic                r_hit;
  logic [WAY_W-1:0]    r_way;
  logic                r_l2_valid;
  logic [1:0]          r_l2_op;
  logic [ADDR_W-1:0]   r_l2_addr;
  logic [CNT_W-1:0]    r_reads;
  logic [CNT_W-1:0]    r_writes;
  logic [CNT_W-1:0]    r_hits;
  logic [CNT_W-1:0]    r_misses;

  logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
  logic [AGE_W-1:0]    r_age   [SETS][WAYS];
  logic [WAYS-1:0]     r_valid [SETS];
  logic [WAYS-1:0]     r_dirty [SETS];

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [ADDR_W-1:0]   w_line_addr;
  logic [ADDR_W-1:0]   w_victim_addr;
  logic                w_way_dirty;
  logic                w_is_rd, w_is_wr, w_is_snoop, w_is_disc;
  logic                w_hit;
  logic [WAY_W-1:0]    w_hit_way;
  logic [WAY_W-1:0]    w_victim;
  logic                w_inv_found;
  logic                w_accept, w_emit, w_need_wb;
  logic [1:0]          w_emit_op;
  logic [ADDR_W-1:0]   w_emit_addr;
  logic                w_alloc, w_touch, w_set_dirty, w_inval, w_discard;
  logic                w_cnt_rd, w_cnt_wr, w_cnt_hit, w_cnt_miss;
  logic                w_unused_ofs;

  assign w_unused_ofs  = ^addr[OFF_W-1:0];
  assign w_idx         = r_line[IDX_W-1:0];
  assign w_tag         = r_line[LINE_W-1:IDX_W];
  assign w_line_addr   = {r_line, {OFF_W{1'b0}}};
  assign w_victim_addr = {r_tag[w_idx][r_way], w_idx, {OFF_W{1'b0}}};
  assign w_way_dirty   = r_valid[w_idx][r_way] && r_dirty[w_idx][r_way];
  assign w_is_rd       = (r_cmd == 4'd0);
  assign w_is_wr       = (r_cmd == 4'd1);
  assign w_is_snoop    = (r_cmd == 4'd2);
  assign w_is_disc     = (r_cmd == 4'd3);

  assign cmd_ready  = r_cmd_ready;
  assign l2_valid   = r_l2_valid;
  assign l2_op      = r_l2_op;
  assign l2_addr    = r_l2_addr;
  assign reads_cnt  = r_reads;
  assign writes_cnt = r_writes;
  assign hits_cnt   = r_hits;
  assign misses_cnt = r_misses;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Parallel tag compare and victim choice: lowest invalid way, else the oldest way.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_victim    = '0;
    w_inv_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!w_inv_found && !r_valid[w_idx][w]) begin
        w_inv_found = 1'b1;
        w_victim    = WAY_W'(w);
      end
    end
    if (!w_inv_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[w_idx][w] == AGE_W'(WAYS - 1)) w_victim = WAY_W'(w);
      end
    end
  end

  // FSM state register; cmd_ready mirrors the IDLE state.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
    end
  end

  // FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (cmd_valid) w_state_nxt = S_LOOKUP;
      S_LOOKUP: w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = w_need_wb ? S_WB : S_IDLE;
      S_WB:     w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: per-state array/counter update strobes and the message to emit.
  always_comb begin
    w_accept    = 1'b0;
    w_emit      = 1'b0;
    w_emit_op   = 2'd0;
    w_emit_addr = '0;
    w_need_wb   = 1'b0;
    w_alloc     = 1'b0;
    w_touch     = 1'b0;
    w_set_dirty = 1'b0;
    w_inval     = 1'b0;
    w_discard   = 1'b0;
    w_cnt_rd    = 1'b0;
    w_cnt_wr    = 1'b0;
    w_cnt_hit   = 1'b0;
    w_cnt_miss  = 1'b0;
    case (r_state)
      S_IDLE: w_accept = cmd_valid;
      S_UPDATE: begin
        if (w_is_rd || w_is_wr) begin
          w_cnt_rd   = w_is_rd;
          w_cnt_wr   = w_is_wr;
          w_cnt_hit  = r_hit;
          w_cnt_miss = !r_hit;
          if (r_hit) begin
            w_touch     = 1'b1;
            w_set_dirty = w_is_wr && !WRITE_THROUGH;
          end else if (w_is_rd || !WRITE_THROUGH) begin
            w_alloc = 1'b1;
            w_touch = 1'b1;
          end
          if (WRITE_THROUGH && w_is_wr) begin
            w_emit      = 1'b1;
            w_emit_op   = OP_WRITE;
            w_emit_addr = w_line_addr;
          end else if (!r_hit) begin
            w_emit = 1'b1;
            if (w_way_dirty) begin
              w_need_wb   = 1'b1;
              w_emit_op   = OP_WB;
              w_emit_addr = w_victim_addr;
            end else begin
              w_emit_op   = OP_READ;
              w_emit_addr = w_line_addr;
            end
          end
        end else if (w_is_snoop && r_hit) begin
          w_inval = 1'b1;
          if (w_way_dirty) begin
            w_emit      = 1'b1;
            w_emit_op   = OP_WB;
            w_emit_addr = w_line_addr;
          end
        end else if (w_is_disc) begin
          w_discard = 1'b1;
        end
      end
      S_WB: begin
        w_emit      = 1'b1;
        w_emit_op   = OP_READ;
        w_emit_addr = w_line_addr;
      end
      default: ;
    endcase
  end

  // Command capture, lookup result, state arrays, counters and message register.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_cmd      <= '0;
      r_line     <= '0;
      r_hit      <= 1'b0;
      r_way      <= '0;
      r_l2_valid <= 1'b0;
      r_l2_op    <= '0;
      r_l2_addr  <= '0;
      r_reads    <= '0;
      r_writes   <= '0;
      r_hits     <= '0;
      r_misses   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= AGE_W'(w);
      end
    end else begin
      if (w_accept) begin
        r_cmd  <= cmd;
        r_line <= addr[ADDR_W-1:OFF_W];
      end
      if (r_state == S_LOOKUP) begin
        r_hit <= w_hit;
        r_way <= w_hit ? w_hit_way : w_victim;
      end
      r_l2_valid <= w_emit;
      if (w_emit) begin
        r_l2_op   <= w_emit_op;
        r_l2_addr <= w_emit_addr;
      end
      if (w_cnt_rd)   r_reads  <= sat_inc(r_reads);
      if (w_cnt_wr)   r_writes <= sat_inc(r_writes);
      if (w_cnt_hit)  r_hits   <= sat_inc(r_hits);
      if (w_cnt_miss) r_misses <= sat_inc(r_misses);
      if (w_alloc) begin
        r_valid[w_idx][r_way] <= 1'b1;
        r_dirty[w_idx][r_way] <= w_is_wr && !WRITE_THROUGH;
      end
      if (w_set_dirty) r_dirty[w_idx][r_way] <= 1'b1;
      if (w_inval) begin
        r_valid[w_idx][r_way] <= 1'b0;
        r_dirty[w_idx][r_way] <= 1'b0;
      end
      if (w_discard) begin
        for (int s = 0; s < SETS; s++) begin
          r_valid[s] <= '0;
          r_dirty[s] <= '0;
        end
      end
      // Touched way becomes MRU; only younger ways age, keeping a permutation.
      if (w_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == r_way) begin
            r_age[w_idx][w] <= '0;
          end else if (r_age[w_idx][w] < r_age[w_idx][r_way]) begin
            r_age[w_idx][w] <= r_age[w_idx][w] + AGE_W'(1);
          end
        end
      end
    end
  end

  // Tags carry no reset; they are only meaningful under a set valid bit.
  always_ff @(posedge clk) begin
    if (!clear && w_alloc) r_tag[w_idx][r_way] <= w_tag;
  end

endmodule

// File: doc/assoc_cache_ctrl.md
Name: assoc_cache_ctrl

Overview:
- Parametrised N-way set-associative cache controller; successor to the fixed split instruction/data caches.
- Consumes trace commands, one per handshake.
- Keeps tag/valid/dirty/LRU state and emits line-aligned messages to the next-level cache.
- Maintains saturating statistics counters that the stats printer reads.
- One instance serves instruction or data traffic; the top level instantiates it twice.

Parameters:
- ADDR_W, 32, address width in bits.
- SETS, 256, number of sets (power of 2).
- WAYS, 4, associativity (power of 2, 1..16).
- LINE_BYTES, 64, line size in bytes (power of 2).
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock.
- clear  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd  in  4  0=read, 1=write, 2=snoop-invalidate, 3=discard-all; 4..15 accepted with no effect.
- addr  in  ADDR_W  byte address.
- l2_valid  out  1  one-cycle message strobe.
- l2_op  out  2  1=READ, 2=WRITE_BACK, 3=WRITE (write-through only).
- l2_addr  out  ADDR_W  line-aligned address (offset bits zero).
- reads_cnt, writes_cnt, hits_cnt, misses_cnt  out  CNT_W each  statistics counters.

Behaviour:
- Address split: offset = log2(LINE_BYTES) LSBs, then index = log2(SETS) bits, tag = remaining upper bits.
- Handshake: a command is accepted on a rising edge with cmd_valid && cmd_ready. cmd_ready is high only in IDLE. cmd and addr are captured at acceptance.
- FSM: IDLE -> LOOKUP -> UPDATE -> (WB if a dirty victim needs a follow-up READ) -> IDLE.
  - LOOKUP compares all ways in parallel.
  - UPDATE writes arrays, counters and LRU.
- Latency (accept at edge k):
  - l2_valid is registered and fires at edge k+2.
  - Dirty-victim miss: WRITE_BACK (victim address) at k+2, READ at k+3.
  - cmd_ready is high again after k+2, or after k+3 for a dirty-victim miss.
- Read/write hit: reads_cnt/writes_cnt +1, hits_cnt +1, touch LRU. A write hit sets dirty.
- Read/write miss:
  - reads_cnt/writes_cnt +1, misses_cnt +1.
  - Victim = lowest-index invalid way, else the way with age WAYS-1.
  - Allocate with tag, valid=1, dirty=(cmd==write); touch LRU; emit READ of the requested line (write-allocate).
- LRU: per-way age, 0=MRU. On touching way w with age a, every way with age < a increments and w becomes 0. Ages within a set always form a permutation of 0..WAYS-1.
- Snoop-invalidate (2):
  - On a tag match: if dirty, emit WRITE_BACK; then clear valid and dirty. LRU is unchanged.
  - No counters change. On a miss, no action.
- Discard-all (3): clears every valid and dirty bit in a single cycle. No writebacks, counters preserved.
- Counters saturate at all-ones and never wrap.
- Reset: clear high at any edge, including mid-operation, returns the FSM to IDLE and drops any pending WB message. It also sets:
  - cmd_ready=1, l2_valid=0, l2_op=0, l2_addr=0;
  - all counters 0;
  - all valid/dirty bits 0;
  - ages way i = i.
- While clear is high, no command is accepted.

Optional Feature:
- Macro WRITE_THROUGH_EN.
- Defined: dirty bits are never set. Every write (hit or miss) emits an l2_op=3 WRITE of its line at k+2, and a write miss does not allocate. Read misses never produce WRITE_BACK, and snoop-invalidate only clears valid.
- Undefined: write-back / write-allocate behaviour as above.

Test Plan:
1. clear, then read 0x00001040 -> at k+2 l2_valid=1, l2_op=1, l2_addr=0x00001040; reads=1, misses=1. Repeat the read -> no l2_valid; hits=1.
2. Reads 0x0000, 0x4000, 0x8000, 0xC000 (set 0), then 0x0000 (hit), then 0x10000 -> READ 0x10000 and victim is 0x4000. Read 0x4000 -> miss.
3. Write 0x0000, then reads 0x4000, 0x8000, 0xC000, 0x10000 -> WRITE_BACK 0x0000 at k+2, READ 0x10000 at k+3; cmd_ready low until after k+3.
4. Write 0x2000, then snoop-invalidate 0x2000 -> WRITE_BACK 0x2000; counters unchanged. Read 0x2000 -> miss.
5. CNT_W=4: 20 reads of 0x0 -> reads_cnt=15, hits_cnt=15, misses_cnt=1.
6. Assert clear during LOOKUP of a miss -> no l2_valid; next cycle cmd_ready=1 and all counters 0.
